// File: rtl/axi_lite_dot8_pkg.sv
// Shared register offsets, response codes, FSM state and lane helpers for axi_lite_dot8_regs.
package axi_lite_dot8_pkg;

    localparam logic [4:0] ADDR_DATA0    = 5'h00;
    localparam logic [4:0] ADDR_DATA1    = 5'h04;
    localparam logic [4:0] ADDR_DATA2    = 5'h08;
    localparam logic [4:0] ADDR_DATA3    = 5'h0C;
    localparam logic [4:0] ADDR_CTRL     = 5'h10;
    localparam logic [4:0] ADDR_STATUS   = 5'h14;
    localparam logic [4:0] ADDR_RESULT   = 5'h18;
    localparam logic [4:0] ADDR_UNMAPPED = 5'h1C;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        IDLE,
        BUSY
    } dot8_state_e;

    typedef logic [2:0] lane_idx_t;

    // Signed 8x8 product, sign-extended so it can be added straight into the accumulator.
    function automatic logic signed [31:0] lane_mac_term(input logic signed [7:0] a,
                                                         input logic signed [7:0] b);
        logic signed [15:0] prod;
        prod = a * b;
        return {{16{prod[15]}}, prod};
    endfunction

endpackage

// File: rtl/axi_lite_dot8_regs_if.sv
// AXI4-Lite bus bundle between the master and the axi_lite_dot8_regs slave.
interface axi_lite_dot8_regs_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   AWADDR;
    logic [2:0]          AWPROT;
    logic                AWVALID;
    logic                AWREADY;
    logic [DATA_W-1:0]   WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic                WVALID;
    logic                WREADY;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;
    logic [ADDR_W-1:0]   ARADDR;
    logic [2:0]          ARPROT;
    logic                ARVALID;
    logic                ARREADY;
    logic [DATA_W-1:0]   RDATA;
    logic [1:0]          RRESP;
    logic                RVALID;
    logic                RREADY;

    modport master (
        output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
               ARADDR, ARPROT, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
               ARADDR, ARPROT, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

endinterface

// File: rtl/dot8_mac_engine.sv
// Sequential int8 dot-product engine: one lane per cycle into a 32-bit accumulator.
module dot8_mac_engine
    import axi_lite_dot8_pkg::*;
#(
    parameter int NUM_LANES = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [8*NUM_LANES-1:0] vec_a_i,
    input  logic [8*NUM_LANES-1:0] vec_b_i,
    input  logic                   start_i,
    output logic                   busy_o,
    output logic                   done_pulse_o,
    output logic [31:0]            result_o
);

    localparam lane_idx_t LAST_LANE = lane_idx_t'(NUM_LANES - 1);

    dot8_state_e        state_q, state_d;
    lane_idx_t          lane_q, lane_d;
    logic signed [31:0] acc_q, acc_d;
    logic signed [31:0] term;
    logic signed [31:0] sum;

    assign term     = lane_mac_term(vec_a_i[{lane_q, 3'b000} +: 8], vec_b_i[{lane_q, 3'b000} +: 8]);
    assign sum      = acc_q + term;
    assign busy_o   = (state_q == BUSY);
    // The final sum is presented alongside done_pulse_o so the owner can capture it that cycle.
    assign result_o = sum;

    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        acc_d        = acc_q;
        done_pulse_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = BUSY;
                    lane_d  = '0;
                    acc_d   = '0;
                end
            end
            BUSY: begin
                acc_d  = sum;
                lane_d = lane_q + 3'd1;
                if (lane_q == LAST_LANE) begin
                    state_d      = IDLE;
                    done_pulse_o = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            lane_q  <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: rtl/axi_lite_dot8_regs.sv
// AXI4-Lite register block (vectors A/B, CTRL, STATUS, RESULT) around dot8_mac_engine.
// Define DOT8_IRQ_EN to add a level irq output that mirrors STATUS.DONE.
module axi_lite_dot8_regs
    import axi_lite_dot8_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int NUM_LANES          = 8
) (
    input  logic                S_AXI_ACLK,
    input  logic                S_AXI_ARESETN,
`ifdef DOT8_IRQ_EN
    output logic                irq,
`endif
    axi_lite_dot8_regs_if.slave s_axi
);

    logic [C_S_AXI_DATA_WIDTH-1:0] data_q [4];
    logic [C_S_AXI_DATA_WIDTH-1:0] data_d [4];
    logic [3:0]                    data_we;
    logic [C_S_AXI_ADDR_WIDTH-1:0] wr_addr, rd_addr;
    logic                          wr_fire, rd_fire;
    logic                          ctrl_start, ctrl_clr;
    logic                          start, clr, done_w1c;
    logic                          busy, done_pulse;
    logic [31:0]                   mac_result;
    logic [1:0]                    wr_resp, bresp_q;
    logic                          bvalid_q, rvalid_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                          done_q, done_d;
    logic [31:0]                   result_q, result_d;
    logic                          unused_ok;

    assign wr_addr    = {s_axi.AWADDR[C_S_AXI_ADDR_WIDTH-1:2], 2'b00};
    assign rd_addr    = {s_axi.ARADDR[C_S_AXI_ADDR_WIDTH-1:2], 2'b00};
    assign wr_fire    = s_axi.AWVALID & s_axi.WVALID & ~bvalid_q;
    assign rd_fire    = s_axi.ARVALID & ~rvalid_q;
    assign ctrl_start = s_axi.WDATA[0] & s_axi.WSTRB[0];
    assign ctrl_clr   = s_axi.WDATA[1] & s_axi.WSTRB[0];

    assign s_axi.AWREADY = wr_fire;
    assign s_axi.WREADY  = wr_fire;
    assign s_axi.BVALID  = bvalid_q;
    assign s_axi.BRESP   = bresp_q;
    assign s_axi.ARREADY = rd_fire;
    assign s_axi.RVALID  = rvalid_q;
    assign s_axi.RDATA   = rdata_q;
    assign s_axi.RRESP   = RESP_OKAY;

    assign unused_ok = ^{s_axi.AWPROT, s_axi.ARPROT, s_axi.AWADDR[1:0], s_axi.ARADDR[1:0]};

`ifdef DOT8_IRQ_EN
    assign irq = done_q;
`endif

    dot8_mac_engine #(
        .NUM_LANES(NUM_LANES)
    ) u_mac (
        .clk_i       (S_AXI_ACLK),
        .rst_ni      (S_AXI_ARESETN),
        .vec_a_i     ({data_q[1], data_q[0]}),
        .vec_b_i     ({data_q[3], data_q[2]}),
        .start_i     (start),
        .busy_o      (busy),
        .done_pulse_o(done_pulse),
        .result_o    (mac_result)
    );

    // Operands must stay frozen during a run, so data/CTRL writes are refused while busy;
    // a redundant START is tolerated silently.
    always_comb begin
        wr_resp  = RESP_OKAY;
        data_we  = '0;
        start    = 1'b0;
        clr      = 1'b0;
        done_w1c = 1'b0;
        if (wr_fire) begin
            case (wr_addr)
                ADDR_DATA0, ADDR_DATA1, ADDR_DATA2, ADDR_DATA3: begin
                    if (busy) wr_resp = RESP_SLVERR;
                    else      data_we[wr_addr[3:2]] = 1'b1;
                end
                ADDR_CTRL: begin
                    if (busy) begin
                        if (!ctrl_start) wr_resp = RESP_SLVERR;
                    end else begin
                        start = ctrl_start;
                        clr   = ctrl_clr;
                    end
                end
                ADDR_STATUS: done_w1c = s_axi.WDATA[1] & s_axi.WSTRB[0];
                default: ;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            data_d[i] = data_q[i];
            for (int b = 0; b < C_S_AXI_DATA_WIDTH / 8; b++) begin
                if (data_we[i] && s_axi.WSTRB[b]) data_d[i][8*b +: 8] = s_axi.WDATA[8*b +: 8];
            end
        end
    end

    // A completing run beats a same-cycle W1C of DONE.
    always_comb begin
        done_d   = done_q;
        result_d = result_q;
        if (clr) begin
            done_d   = 1'b0;
            result_d = '0;
        end
        if (done_w1c) done_d = 1'b0;
        if (done_pulse) begin
            done_d   = 1'b1;
            result_d = mac_result;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd_fire) begin
            rdata_d = '0;
            case (rd_addr)
                ADDR_DATA0, ADDR_DATA1, ADDR_DATA2, ADDR_DATA3: rdata_d = data_q[rd_addr[3:2]];
                ADDR_STATUS: begin
                    rdata_d[0] = busy;
                    rdata_d[1] = done_q;
                end
                ADDR_RESULT: rdata_d = result_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int i = 0; i < 4; i++) data_q[i] <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            for (int i = 0; i < 4; i++) data_q[i] <= data_d[i];
            done_q   <= done_d;
            result_q <= result_d;
            rdata_q  <= rdata_d;
            if (wr_fire) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_resp;
            end else if (s_axi.BREADY) begin
                bvalid_q <= 1'b0;
            end
            if (rd_fire)           rvalid_q <= 1'b1;
            else if (s_axi.RREADY) rvalid_q <= 1'b0;
        end
    end

endmodule
